// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//   Shared definitions for the 7-segment scan capture block.
//   - Active-low segment codes for the digits 0..9 (bit6=g ... bit0=a) and the
//     all-off blank code.
//   - Capture FSM state encoding.
//   - Decoder result record {err, val}.
// -----------------------------------------------------------------------------
package seg7_pkg;

  // Active-low segment patterns as driven by the display encoder.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Value reported for any pattern that is not one of the ten digits.
  localparam logic [3:0] BCD_INVALID = 4'hF;

  // Capture FSM states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,  // bus blank, nothing selected
    S_SETTLE = 2'd1,  // a digit is selected, waiting for the sample to settle
    S_HELD   = 2'd2   // current sample already committed
  } cap_state_e;

  // Decoder output.
  typedef struct packed {
    logic       err;  // 1 = pattern is not a decimal digit
    logic [3:0] val;  // BCD value, BCD_INVALID when err=1
  } seg_dec_t;

endpackage : seg7_pkg

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
//   Combinational inverse of the display encoder: maps an active-low 7-segment
//   pattern back to its BCD value. Only the ten exact digit patterns decode;
//   everything else (including blank and partially lit patterns) reports
//   err=1 with value 4'hF.
// Ports
//   seg_code  in   7   active-low segment pattern, bit6=g ... bit0=a
//   dec       out  5   {err, val}
// -----------------------------------------------------------------------------
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_code,
  output seg_dec_t   dec
);

  // Exact-match lookup of the ten digit patterns.
  always_comb begin
    dec.err = 1'b0;
    dec.val = 4'd0;
    case (seg_code)
      SEG_0:   dec.val = 4'd0;
      SEG_1:   dec.val = 4'd1;
      SEG_2:   dec.val = 4'd2;
      SEG_3:   dec.val = 4'd3;
      SEG_4:   dec.val = 4'd4;
      SEG_5:   dec.val = 4'd5;
      SEG_6:   dec.val = 4'd6;
      SEG_7:   dec.val = 4'd7;
      SEG_8:   dec.val = 4'd8;
      SEG_9:   dec.val = 4'd9;
      default: begin
        dec.err = 1'b1;
        dec.val = BCD_INVALID;
      end
    endcase
  end

endmodule : seg7_decode

// File: rtl/seg7_scan_capture.sv
// -----------------------------------------------------------------------------
// seg7_scan_capture
//   Receive end of a multiplexed 7-segment display bus. The raw segment and
//   anode lines are synchronised, each settled {anode, segment} sample is
//   decoded back to BCD and stored per digit. Scan transitions and ghosting
//   are rejected by requiring the sample to stay identical for STABLE_CNT
//   consecutive comparisons before it is committed.
// Parameters
//   DIGITS      number of multiplexed digits (anode width)
//   STABLE_CNT  identical consecutive comparisons required before commit (>=2)
//   CNT_W       stability counter width, must hold STABLE_CNT-1
// Ports
//   clk          in   1          system clock, rising edge
//   rst_n        in   1          asynchronous reset, active low
//   seg_in       in   7          segment lines, active low, bit6=g ... bit0=a
//   anode_in     in   DIGITS     digit select, active low, one-hot-low when valid
//   digit_val    out  4*DIGITS   captured BCD per digit, digit i at [4i+3:4i]
//   digit_err    out  DIGITS     1 = last commit of digit i was undecodable
//   frame_valid  out  1          pulse: every digit committed since last pulse
//   anode_err    out  1          pulse: settled sample had more than one anode low
// -----------------------------------------------------------------------------
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     anode_in,
  output logic [4*DIGITS-1:0]   digit_val,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid,
  output logic                  anode_err
);

  localparam int               SMP_W    = DIGITS + 7;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  // ---------------------------------------------------------------------------
  // Synchroniser and sample history. Reset to all-ones so the pipeline looks
  // like a blank bus and no spurious selection is seen after reset.
  // ---------------------------------------------------------------------------
  logic [SMP_W-1:0] sync1_q, sync1_d;
  logic [SMP_W-1:0] sync2_q, sync2_d;
  logic [SMP_W-1:0] prev_q,  prev_d;

  logic [DIGITS-1:0] smp_anode;
  logic [6:0]        smp_seg;
  logic [DIGITS-1:0] low_vec;
  logic              same;
  logic              blank;
  logic              multi_low;

  // Capture FSM and stability counter.
  cap_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              commit;

  // Per-digit results and frame tracking.
  logic [4*DIGITS-1:0] digit_val_q, digit_val_d;
  logic [DIGITS-1:0]   digit_err_q, digit_err_d;
  logic [DIGITS-1:0]   seen_q,      seen_d;
  logic [DIGITS-1:0]   seen_next;
  logic [DIGITS-1:0]   commit_mask;
  logic                frame_valid_q, frame_valid_d;
  logic                anode_err_q,   anode_err_d;

  seg_dec_t            dec;

  // Decoder for the synchronised segment pattern.
  seg7_decode u_decode (
    .seg_code (smp_seg),
    .dec      (dec)
  );

  // Next values of the input pipeline and sample classification.
  always_comb begin
    sync1_d   = {anode_in, seg_in};
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    smp_anode = sync2_q[SMP_W-1:7];
    smp_seg   = sync2_q[6:0];
    low_vec   = ~smp_anode;
    same      = (sync2_q == prev_q);
    blank     = &smp_anode;
    // Clearing the lowest set bit leaves something only if two or more are set.
    multi_low = |(low_vec & (low_vec - {{(DIGITS-1){1'b0}}, 1'b1}));
  end

  // Capture FSM next-state: wait for a selection, count identical samples,
  // commit once, then hold until the sample changes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!blank) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (blank) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!same) begin
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit  = 1'b1;
          state_d = S_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_HELD: begin
        if (!same) begin
          state_d = blank ? S_IDLE : S_SETTLE;
          cnt_d   = '0;
        end else begin
          state_d = S_HELD;
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Commit datapath: write the selected digit, track which digits have been
  // seen this frame, and flag ghosted (multi-anode) samples instead of writing.
  always_comb begin
    if (commit && !multi_low) begin
      commit_mask = low_vec;
    end else begin
      commit_mask = '0;
    end

    digit_val_d = digit_val_q;
    digit_err_d = digit_err_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (commit_mask[i]) begin
        digit_val_d[4*i +: 4] = dec.val;
        digit_err_d[i]        = dec.err;
      end else begin
        digit_val_d[4*i +: 4] = digit_val_q[4*i +: 4];
        digit_err_d[i]        = digit_err_q[i];
      end
    end

    // The completing commit itself counts toward the frame; seen restarts
    // empty so a commit in the pulse cycle begins the next frame.
    seen_next = seen_q | commit_mask;
    if (&seen_next) begin
      frame_valid_d = 1'b1;
      seen_d        = '0;
    end else begin
      frame_valid_d = 1'b0;
      seen_d        = seen_next;
    end

    anode_err_d = commit && multi_low;
  end

  // Input synchroniser and previous-sample register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // Capture FSM state and stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Per-digit result registers, seen vector and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_val_q   <= '0;
      digit_err_q   <= '0;
      seen_q        <= '0;
      frame_valid_q <= 1'b0;
      anode_err_q   <= 1'b0;
    end else begin
      digit_val_q   <= digit_val_d;
      digit_err_q   <= digit_err_d;
      seen_q        <= seen_d;
      frame_valid_q <= frame_valid_d;
      anode_err_q   <= anode_err_d;
    end
  end

  assign digit_val   = digit_val_q;
  assign digit_err   = digit_err_q;
  assign frame_valid = frame_valid_q;
  assign anode_err   = anode_err_q;

endmodule : seg7_scan_capture

// File: tb/tb_seg7_scan_capture.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_capture
//   Scoreboard bench. The stimulus side feeds every driven {anode, seg} into a
//   run-length reference model: a value held for STABLE_CNT+1 consecutive
//   cycles commits once. Each expected commit is queued with the cycle on which
//   its effect must be visible; a separate monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_seg7_scan_capture;

  localparam int DIGITS     = 8;
  localparam int STABLE_CNT = 4;
  localparam int LAT        = 3;  // 2 sync stages + registered commit

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [6:0]           seg_in;
  logic [DIGITS-1:0]    anode_in;
  logic [4*DIGITS-1:0]  digit_val;
  logic [DIGITS-1:0]    digit_err;
  logic                 frame_valid;
  logic                 anode_err;

  int checks      = 0;
  int failures    = 0;
  int cyc         = 0;
  int frames_seen = 0;

  logic [6:0] ref_codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    int          cyc;
    logic [31:0] val;
    logic [7:0]  err;
    logic        frame;
    logic        aerr;
  } ev_t;

  ev_t evq[$];

  // Reference model state.
  logic [14:0] m_last;
  int          m_run;
  logic [31:0] m_val;
  logic [7:0]  m_err;
  logic [7:0]  m_seen;

  seg7_scan_capture #(
    .DIGITS     (DIGITS),
    .STABLE_CNT (STABLE_CNT),
    .CNT_W      (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .anode_in    (anode_in),
    .digit_val   (digit_val),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .anode_err   (anode_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic void ref_decode(input logic [6:0] code, output logic [3:0] v, output logic e);
    v = 4'hF;
    e = 1'b1;
    for (int d = 0; d < 10; d++) begin
      if (ref_codes[d] == code) begin
        v = 4'(d);
        e = 1'b0;
      end
    end
  endfunction

  task automatic model_reset();
    evq.delete();
    m_last = 15'h7FFF;
    m_run  = 0;
    m_val  = 32'h0;
    m_err  = 8'h0;
    m_seen = 8'h0;
  endtask

  // One driven cycle into the model: count how long the same value has been on
  // the bus; the (STABLE_CNT+1)-th identical cycle of a non-blank value commits.
  task automatic model_step(input logic [7:0] a, input logic [6:0] s);
    logic [7:0] low;
    logic [3:0] dv;
    logic       de;
    int         k;
    ev_t        e;
    if ({a, s} == m_last) begin
      m_run++;
    end else begin
      m_last = {a, s};
      m_run  = 1;
    end
    if (m_run == STABLE_CNT + 1 && a != 8'hFF) begin
      low     = ~a;
      e.cyc   = cyc + LAT;
      e.frame = 1'b0;
      e.aerr  = 1'b0;
      if ($countones(low) > 1) begin
        e.aerr = 1'b1;
      end else begin
        k = 0;
        for (int i = 0; i < 8; i++) if (low[i]) k = i;
        ref_decode(s, dv, de);
        m_val[4*k +: 4] = dv;
        m_err[k]        = de;
        m_seen[k]       = 1'b1;
        if (m_seen == 8'hFF) begin
          e.frame = 1'b1;
          m_seen  = 8'h00;
        end
      end
      e.val = m_val;
      e.err = m_err;
      evq.push_back(e);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [6:0] s);
    @(posedge clk);
    #1;
    anode_in = a;
    seg_in   = s;
    model_step(a, s);
  endtask

  task automatic hold(input logic [7:0] a, input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) drive(a, s);
  endtask

  task automatic settle_and_check(input string tag);
    hold(8'hFF, 7'h7F, 6);
    @(negedge clk);
    chk({tag, "_val"}, digit_val, m_val);
    chk({tag, "_err"}, 32'(digit_err), 32'(m_err));
    chk({tag, "_pending"}, 32'(evq.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    anode_in = 8'hFF;
    seg_in   = 7'h7F;
    model_reset();
    #1;
    chk("areset_val", digit_val, 32'h0);
    chk("areset_err", 32'(digit_err), 32'h0);
    chk("areset_pulses", {30'd0, frame_valid, anode_err}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: on the cycle a commit is due, compare everything; otherwise no
  // status pulse may appear.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (rst_n) begin
      if (frame_valid) frames_seen++;
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        e = evq.pop_front();
        chk("missed_event_cycle", 32'(cyc), 32'(e.cyc));
      end
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        e = evq.pop_front();
        chk("digit_val", digit_val, e.val);
        chk("digit_err", 32'(digit_err), 32'(e.err));
        chk("frame_valid", 32'(frame_valid), 32'(e.frame));
        chk("anode_err", 32'(anode_err), 32'(e.aerr));
      end else begin
        chk("idle_pulses", {30'd0, frame_valid, anode_err}, 32'h0);
      end
    end
  end

  initial begin : stimulus
    int         f0;
    logic [7:0] a;
    logic [6:0] s;
    int         i0;
    int         j0;
    int         sel;

    // 1: reset with random inputs, outputs must be zero.
    rst_n    = 1'b0;
    anode_in = 8'hFF;
    seg_in   = 7'h7F;
    model_reset();
    for (int n = 0; n < 4; n++) begin
      @(posedge clk);
      #1;
      anode_in = 8'($urandom);
      seg_in   = 7'($urandom);
      @(negedge clk);
      chk("rst_val", digit_val, 32'h0);
      chk("rst_err", 32'(digit_err), 32'h0);
      chk("rst_pulses", {30'd0, frame_valid, anode_err}, 32'h0);
    end
    @(posedge clk);
    #1;
    anode_in = 8'hFF;
    seg_in   = 7'h7F;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(8'hFF, 7'h7F, 8);
    settle_and_check("blank_after_reset");

    // 2: digit 2 shows 3.
    hold(8'hFB, 7'h30, 6);
    settle_and_check("digit2");
    chk("digit2_nibble", 32'(digit_val[11:8]), 32'd3);
    chk("digit2_err", 32'(digit_err[2]), 32'd0);

    // 3: too-short glitch never commits.
    hold(8'hFE, 7'h12, 3);
    settle_and_check("glitch");
    chk("glitch_nibble", 32'(digit_val[3:0]), 32'd0);

    // 4: full scan 1..8, exactly one frame pulse.
    f0 = frames_seen;
    for (int d = 0; d < 8; d++) begin
      a = ~(8'h01 << d);
      hold(a, ref_codes[d + 1], 5);
    end
    settle_and_check("scan");
    chk("scan_value", digit_val, 32'h8765_4321);
    chk("scan_frames", 32'(frames_seen - f0), 32'd1);

    // 5: blank pattern on digit 5 is an error, then a valid 0 clears it.
    hold(8'hDF, 7'h7F, 6);
    settle_and_check("d5_blank");
    chk("d5_blank_nibble", 32'(digit_val[23:20]), 32'hF);
    chk("d5_blank_err", 32'(digit_err[5]), 32'd1);
    hold(8'hDF, 7'h40, 6);
    settle_and_check("d5_zero");
    chk("d5_zero_nibble", 32'(digit_val[23:20]), 32'd0);
    chk("d5_zero_err", 32'(digit_err[5]), 32'd0);

    // 6: ghosted anodes, then reset mid-frame clears seen.
    hold(8'hFC, 7'h30, 5);
    settle_and_check("ghost");
    for (int d = 1; d < 8; d++) begin
      a = ~(8'h01 << d);
      hold(a, ref_codes[$urandom_range(0, 9)], 5);
    end
    do_reset();
    hold(8'hFF, 7'h7F, 3);
    f0 = frames_seen;
    for (int d = 0; d < 8; d++) begin
      a = ~(8'h01 << d);
      hold(a, ref_codes[$urandom_range(0, 9)], 5);
    end
    settle_and_check("post_reset_scan");
    chk("post_reset_frames", 32'(frames_seen - f0), 32'd1);

    // Every 7-bit pattern through the decoder.
    for (int c = 0; c < 128; c++) begin
      a = ~(8'h01 << (c % 8));
      hold(a, 7'(c), 5);
    end
    settle_and_check("sweep");

    // Random scans: mostly clean digits, with blanks, ghosts and garbage.
    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7) begin
        a = ~(8'h01 << $urandom_range(0, 7));
      end else if (sel == 7) begin
        a = 8'hFF;
      end else if (sel == 8) begin
        i0 = $urandom_range(0, 7);
        j0 = (i0 + 1 + $urandom_range(0, 6)) % 8;
        a  = 8'hFF;
        a[i0] = 1'b0;
        a[j0] = 1'b0;
      end else begin
        a = 8'($urandom);
      end
      if ($urandom_range(0, 9) < 8) s = ref_codes[$urandom_range(0, 9)];
      else                          s = 7'($urandom);
      hold(a, s, $urandom_range(1, 7));
    end
    settle_and_check("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seg7_scan_capture
